// File: rtl/ctrl_cond_pkg.sv
// Shared encodings for the control input conditioner.
// Stretch FSM states and inactive input levels.
package ctrl_cond_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic SW_RST_VAL    = 1'b0;
  localparam logic BTN_N_RST_VAL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_ASSERT = ASSERT,
    S_HOLD   = HOLD
  } state_t;

endpackage

// File: rtl/ctrl_input_conditioner_if.sv
// VIO-side control bundle of the input conditioner.
// master drives selection/VIO requests, slave returns the conditioned levels.
interface ctrl_input_conditioner_if;

  logic sel_vio;
  logic sw_vio;
  logic rst_vio;
  logic sw;
  logic sw_edge;
  logic sys_rst;
  logic sel_active;

  modport master (
    output sel_vio, sw_vio, rst_vio,
    input  sw, sw_edge, sys_rst, sel_active
  );

  modport slave (
    input  sel_vio, sw_vio, rst_vio,
    output sw, sw_edge, sys_rst, sel_active
  );

endinterface

// File: rtl/ctrl_debounce.sv
// Synchronizer chain plus stable-count debouncer for one
// asynchronous board input.
module ctrl_debounce #(
  parameter int   NB_SYNC         = 2,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   NB_DBNC         = 20,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level
);

  localparam logic [NB_DBNC-1:0] CNT_MAX =
    NB_DBNC'(DEBOUNCE_CYCLES - 1);

  logic [NB_SYNC-1:0] r_sync;
  logic [NB_DBNC-1:0] r_cnt;
  logic               r_level;
  logic               w_synced;

  assign w_synced = r_sync[NB_SYNC-1];
  assign o_level  = r_level;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_sync  <= {NB_SYNC{RST_VAL}};
      r_cnt   <= '0;
      r_level <= RST_VAL;
    end else begin
      r_sync <= {r_sync[NB_SYNC-2:0], i_async};
      if (w_synced == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + NB_DBNC'(1);
      end
    end
  end

endmodule

// File: rtl/ctrl_input_conditioner.sv
// Board/VIO control input conditioner with stretched system reset.
// Define CTRL_RST_CNT_EN to add the o_rst_cnt reset-event counter.
module ctrl_input_conditioner
  import ctrl_cond_pkg::*;
#(
  parameter int NB_SYNC         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_DBNC         = 20,
  parameter int RST_STRETCH     = 16,
  parameter int NB_STRETCH      = 5
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_sw_phy,
  input  logic       i_rst_btn_n,
  input  logic       i_sel_vio,
  input  logic       i_sw_vio,
  input  logic       i_rst_vio,
  output logic       o_sw,
  output logic       o_sw_edge,
  output logic       o_sys_rst,
  output logic       o_sel_active
`ifdef CTRL_RST_CNT_EN
  ,output logic [7:0] o_rst_cnt
`endif
);

  localparam logic [NB_STRETCH-1:0] STRETCH_INIT =
    NB_STRETCH'(RST_STRETCH);

  logic w_sw_db;
  logic w_btn_n_db;
  logic w_sw_sel;
  logic w_change;
  logic w_req;

  logic r_sel;
  logic r_sel_prev;
  logic r_sw;
  logic r_sw_edge;
  logic r_sys_rst;

  state_t                r_state;
  logic [NB_STRETCH-1:0] r_cnt;

  ctrl_debounce #(
    .NB_SYNC         (NB_SYNC),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .NB_DBNC         (NB_DBNC),
    .RST_VAL         (SW_RST_VAL)
  ) u_sw_dbnc (
    .clk     (clk),
    .i_reset (i_reset),
    .i_async (i_sw_phy),
    .o_level (w_sw_db)
  );

  ctrl_debounce #(
    .NB_SYNC         (NB_SYNC),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .NB_DBNC         (NB_DBNC),
    .RST_VAL         (BTN_N_RST_VAL)
  ) u_btn_dbnc (
    .clk     (clk),
    .i_reset (i_reset),
    .i_async (i_rst_btn_n),
    .o_level (w_btn_n_db)
  );

  assign w_sw_sel = r_sel ? i_sw_vio : w_sw_db;
  assign w_change = r_sel ^ r_sel_prev;
  assign w_req    = (r_sel ? i_rst_vio : ~w_btn_n_db)
                  | w_change;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_sel      <= 1'b0;
      r_sel_prev <= 1'b0;
      r_sw       <= SW_RST_VAL;
      r_sw_edge  <= 1'b0;
    end else begin
      r_sel      <= i_sel_vio;
      r_sel_prev <= r_sel;
      r_sw       <= w_sw_sel;
      r_sw_edge  <= w_sw_sel ^ r_sw;
    end
  end

  // Request is held through ASSERT; HOLD counts down the tail.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= S_HOLD;
      r_cnt     <= STRETCH_INIT;
      r_sys_rst <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state   <= S_ASSERT;
            r_sys_rst <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (!w_req) begin
            r_state <= S_HOLD;
            r_cnt   <= STRETCH_INIT;
          end
        end
        S_HOLD: begin
          if (w_req) begin
            r_state <= S_ASSERT;
          end else if (r_cnt == NB_STRETCH'(1)) begin
            r_state   <= S_IDLE;
            r_sys_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt - NB_STRETCH'(1);
          end
        end
        default: begin
          r_state   <= S_HOLD;
          r_cnt     <= STRETCH_INIT;
          r_sys_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef CTRL_RST_CNT_EN
  logic [7:0] r_rst_cnt;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_rst_cnt <= '0;
    end else if (r_state == S_IDLE && w_req
                 && r_rst_cnt != 8'hFF) begin
      r_rst_cnt <= r_rst_cnt + 8'd1;
    end
  end

  assign o_rst_cnt = r_rst_cnt;
`endif

  assign o_sw         = r_sw;
  assign o_sw_edge    = r_sw_edge & ~r_sys_rst;
  assign o_sys_rst    = r_sys_rst;
  assign o_sel_active = r_sel;

endmodule

// File: tb/tb_ctrl_input_conditioner.sv
// Directed bench for ctrl_input_conditioner (short debounce/stretch).
// Table of per-cycle VIO vectors plus hand sequences for physical paths.
module tb_ctrl_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic sw_phy;
  logic btn_n;

  int errors = 0;
  int checks = 0;

  ctrl_input_conditioner_if vif ();

`ifdef CTRL_RST_CNT_EN
  logic [7:0] rst_cnt;
`endif

  ctrl_input_conditioner #(
    .NB_SYNC         (2),
    .DEBOUNCE_CYCLES (8),
    .NB_DBNC         (4),
    .RST_STRETCH     (4),
    .NB_STRETCH      (3)
  ) dut (
    .clk          (clk),
    .i_reset      (reset),
    .i_sw_phy     (sw_phy),
    .i_rst_btn_n  (btn_n),
    .i_sel_vio    (vif.sel_vio),
    .i_sw_vio     (vif.sw_vio),
    .i_rst_vio    (vif.rst_vio),
    .o_sw         (vif.sw),
    .o_sw_edge    (vif.sw_edge),
    .o_sys_rst    (vif.sys_rst),
    .o_sel_active (vif.sel_active)
`ifdef CTRL_RST_CNT_EN
    ,.o_rst_cnt   (rst_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic sel;
    logic swv;
    logic rv;
    logic esw;
    logic erst;
    logic esel;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, sel, swv, rv,
                     input logic esw, erst, esel);
    vec_t v;
    v = '{rst, sel, swv, rv, esw, erst, esel};
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  int first;
  int high;
  int bad;
  int edges;

  initial begin
    reset       = 1'b1;
    sw_phy      = 1'b0;
    btn_n       = 1'b1;
    vif.sel_vio = 1'b0;
    vif.sw_vio  = 1'b0;
    vif.rst_vio = 1'b0;

    // rst sel swv rv | sw sys_rst sel_active
    add(1,0,0,0, 0,1,0);
    add(1,0,0,0, 0,1,0);
    add(0,0,0,0, 0,1,0);
    add(0,0,0,0, 0,1,0);
    add(0,0,0,0, 0,1,0);
    add(0,0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    // changeover to VIO
    add(0,1,0,0, 0,0,1);
    add(0,1,0,0, 0,1,1);
    add(0,1,0,0, 0,1,1);
    add(0,1,0,0, 0,1,1);
    add(0,1,0,0, 0,1,1);
    add(0,1,0,0, 0,1,1);
    add(0,1,0,0, 0,0,1);
    // VIO switch, 1-cycle latency
    add(0,1,1,0, 1,0,1);
    add(0,1,0,0, 0,0,1);
    add(0,1,1,0, 1,0,1);
    // 2-cycle VIO reset request
    add(0,1,1,1, 1,1,1);
    add(0,1,1,1, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,0,1);
    // request during HOLD restarts stretch
    add(0,1,1,1, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,1, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,1,1);
    add(0,1,1,0, 1,0,1);
    // back to physical; VIO switch ignored
    add(0,0,1,0, 1,0,0);
    add(0,0,1,0, 0,1,0);
    add(0,0,1,0, 0,1,0);
    add(0,0,1,0, 0,1,0);
    add(0,0,1,0, 0,1,0);
    add(0,0,1,0, 0,1,0);
    add(0,0,1,0, 0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      reset       = vq[i].rst;
      vif.sel_vio = vq[i].sel;
      vif.sw_vio  = vq[i].swv;
      vif.rst_vio = vq[i].rv;
      step();
      chk($sformatf("row%0d o_sw", i),
          int'(vif.sw), int'(vq[i].esw));
      chk($sformatf("row%0d o_sys_rst", i),
          int'(vif.sys_rst), int'(vq[i].erst));
      chk($sformatf("row%0d o_sel_active", i),
          int'(vif.sel_active), int'(vq[i].esel));
    end
    vif.sw_vio = 1'b0;
    step();

    // physical switch: 11-cycle latency, one edge
    sw_phy = 1'b1;
    edges  = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      edges += int'(vif.sw_edge);
      if (k == 10) chk("sw_lat_10", int'(vif.sw), 0);
      if (k == 11) chk("sw_lat_11", int'(vif.sw), 1);
    end
    chk("sw_edge_count", edges, 1);

    // 5-cycle glitch rejected
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      sw_phy = (k < 5) ? 1'b0 : 1'b1;
      step();
      if (vif.sw !== 1'b1) bad++;
    end
    chk("sw_glitch", bad, 0);

    sw_phy = 1'b0;
    repeat (12) step();
    chk("sw_release", int'(vif.sw), 0);

    // button press of 20 cycles
    first = 0;
    high  = 0;
    btn_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (vif.sys_rst === 1'b1) begin
        high++;
        if (first == 0) first = k;
      end
      if (k == 20) btn_n = 1'b1;
    end
    chk("btn_rise_cycle", first, 11);
    chk("btn_high_cycles", high, 24);

    // 3-cycle bounce rejected
    high = 0;
    for (int k = 0; k < 30; k++) begin
      btn_n = (k < 3) ? 1'b0 : 1'b1;
      step();
      high += int'(vif.sys_rst);
    end
    chk("btn_bounce", high, 0);

    // VIO selected: physical inputs ignored
    vif.sel_vio = 1'b1;
    repeat (8) step();
    chk("vio_sel_idle", int'(vif.sys_rst), 0);
    btn_n  = 1'b0;
    sw_phy = 1'b1;
    bad    = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (vif.sys_rst !== 1'b0) bad++;
      if (vif.sw !== 1'b0) bad++;
    end
    chk("vio_ignores_phy", bad, 0);
    btn_n = 1'b1;
    repeat (12) step();

    // debouncer kept running while unselected
    vif.sel_vio = 1'b0;
    step();
    chk("back_phy_sw_old", int'(vif.sw), 0);
    step();
    chk("back_phy_sw_db", int'(vif.sw), 1);
    chk("back_phy_rst", int'(vif.sys_rst), 1);
    chk("edge_gated", int'(vif.sw_edge), 0);
    repeat (8) step();
    chk("back_phy_idle", int'(vif.sys_rst), 0);
    sw_phy = 1'b0;
    repeat (12) step();

`ifdef CTRL_RST_CNT_EN
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    chk("cnt_after_reset", int'(rst_cnt), 0);
    for (int p = 0; p < 3; p++) begin
      btn_n = 1'b0;
      repeat (20) step();
      btn_n = 1'b1;
      repeat (20) step();
    end
    chk("cnt_three_press", int'(rst_cnt), 3);
    vif.sel_vio = 1'b1;
    repeat (8) step();
    chk("cnt_changeover", int'(rst_cnt), 4);
    for (int p = 0; p < 300; p++) begin
      vif.rst_vio = 1'b1;
      step();
      vif.rst_vio = 1'b0;
      repeat (7) step();
    end
    chk("cnt_saturate", int'(rst_cnt), 255);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_input_conditioner.md
Name: ctrl_input_conditioner

Overview:
Conditions the board-level control inputs before they reach qpsk_comm_sys, and sits directly upstream of it in the FPGA top.
- Physical path: synchronizes and debounces the slide switch and the active-low reset button.
- Source select: chooses between the physical sources and the VIO sources.
- Reset: produces a stretched, glitch-free system reset plus a registered switch level with an edge pulse.
- Changeover: toggling the VIO/physical selection forces a clean system re-initialization.

Parameters:
NB_SYNC, 2, synchronizer depth for the physical inputs (minimum 2).
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a physical level change (10 ms at 100 MHz).
NB_DBNC, 20, debounce counter width; must satisfy 2^NB_DBNC > DEBOUNCE_CYCLES.
RST_STRETCH, 16, cycles o_sys_rst stays high after the last reset request clears.
NB_STRETCH, 5, stretch counter width; must satisfy 2^NB_STRETCH > RST_STRETCH.

Ports:
clk  in  1  system clock, 100 MHz
i_reset  in  1  block reset; synchronous, active-high
i_sw_phy  in  1  board switch, asynchronous
i_rst_btn_n  in  1  board reset button, asynchronous, active-low
i_sel_vio  in  1  1 = VIO sources, 0 = physical sources (clk domain)
i_sw_vio  in  1  VIO switch (clk domain)
i_rst_vio  in  1  VIO reset request, active-high (clk domain)
o_sw  out  1  conditioned switch level to the datapath
o_sw_edge  out  1  one-cycle pulse on any o_sw change
o_sys_rst  out  1  stretched system reset, active-high
o_sel_active  out  1  registered copy of the applied selection

Behaviour:
- Reset is synchronous and active-high on i_reset; there is a single clock, clk.
- Values while i_reset is high:
  - sync chains: sw 0, btn_n 1
  - debounced levels: sw 0, btn released
  - o_sw 0, o_sw_edge 0, o_sel_active 0
  - o_sys_rst 1; stretch FSM enters HOLD with counter = RST_STRETCH
- Synchronizer: NB_SYNC flops per physical input. VIO inputs are neither synchronized nor debounced.
- Debounce, per physical input:
  - Counter clears whenever the synced value equals the debounced value.
  - Counter increments while the two differ.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Source mux:
  - sel_q registers i_sel_vio.
  - Selected switch = sel_q ? i_sw_vio : debounced sw.
  - o_sw is registered, so the VIO path has 1-cycle latency.
  - Physical path latency is NB_SYNC + DEBOUNCE_CYCLES + 1 cycles.
- o_sw_edge = o_sw XOR its previous value, registered. It is forced to 0 while o_sys_rst is 1.
- Reset request (combinational OR of):
  - (sel_q ? i_rst_vio : debounced button pressed)
  - changeover pulse (sel_q != previous sel_q), one cycle
- Stretch FSM, states IDLE, ASSERT, HOLD:
  - IDLE → ASSERT on request; o_sys_rst = 1 starting the next cycle.
  - ASSERT stays while the request is high. When it drops → HOLD with counter = RST_STRETCH.
  - HOLD decrements each cycle. A new request returns to ASSERT. At counter 1 with no request → IDLE, and o_sys_rst = 0 the following cycle.
  - o_sys_rst = 1 in ASSERT and HOLD.
- Simultaneous events:
  - A changeover and a reset request in the same cycle are a single request.
  - i_reset overrides everything.
- While selection is physical, VIO inputs are ignored, and vice versa. The debouncers keep running on the unselected physical inputs.

Optional Feature:
CTRL_RST_CNT_EN.
- Defined:
  - Adds output o_rst_cnt [7:0], a saturating count (max 255) of IDLE→ASSERT transitions.
  - Cleared by i_reset; the i_reset-induced assertion is not counted.
  - Intended as a VIO probe.
- Undefined: the port and the counter are absent.

Decomposition:
- Package ctrl_cond_pkg holds:
  - FSM state localparams: IDLE=2'd0, ASSERT=2'd1, HOLD=2'd2
  - inactive levels: SW_RST_VAL=0, BTN_N_RST_VAL=1
- Sub-module ctrl_debounce (sync chain + debounce counter, parameters NB_SYNC, DEBOUNCE_CYCLES, NB_DBNC, RST_VAL) is instantiated twice.

Test Plan (DEBOUNCE_CYCLES=8, RST_STRETCH=4, NB_SYNC=2):
- Release i_reset → o_sys_rst stays 1 for exactly 4 more cycles, then 0; o_sw=0; o_sel_active=0.
- sel=0, i_sw_phy 0→1 held → o_sw=1 exactly 11 cycles later with one o_sw_edge pulse. A 5-cycle pulse on i_sw_phy → o_sw unchanged.
- sel=0, i_rst_btn_n low 20 cycles → o_sys_rst rises 11 cycles after press, falls 4 cycles after debounced release. A 3-cycle bounce → no reset.
- sel=1, i_sw_vio toggles → o_sw follows 1 cycle later. i_rst_vio high 2 cycles → o_sys_rst high 6 cycles.
- Toggle i_sel_vio 0→1 → o_sys_rst high 5 cycles (1 changeover + 4 stretch), o_sel_active=1. A second i_rst_vio during HOLD restarts the stretch.
- With CTRL_RST_CNT_EN: three separate button presses → o_rst_cnt=3. 300 VIO requests → o_rst_cnt=255.
